// File: rtl/rmgmt_arb_pkg.sv
// Shared types for the RISC-MGMT memory arbiter: FSM state encoding and index sizing.
// Pure declarations; no logic or latency of its own.
package rmgmt_arb_pkg;

  typedef enum logic {IDLE, ACCESS} rmgmt_arb_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // A single requester still gets a 1-bit index so ports never collapse to zero width.
  function automatic int idx_w(input int n);
    return $clog2(n > 1 ? n : 2);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: the first asserted req at or after ptr, wrapping mod N.
// Purely combinational; req is a level, so there is no backpressure.
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Walk the search order backwards so the candidate nearest ptr overwrites the others.
  always_comb begin
    valid = |req;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/rmgmt_mem_arbiter.sv
// Grants the shared data-memory port to one extension at a time, round-robin.
// Grant 1 cycle after req; done in the first ACCESS cycle with mem_busy=0; stalls the pipe meanwhile.
module rmgmt_mem_arbiter
  import rmgmt_arb_pkg::*;
#(
  parameter int N_EXT = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_EXT-1:0]      ext_req,
  input  logic [N_EXT-1:0]      ext_wen,
  input  logic [32*N_EXT-1:0]   ext_addr,
  input  logic [32*N_EXT-1:0]   ext_wdata,
  input  logic [4*N_EXT-1:0]    ext_byte_en,
  input  logic                  kill,
  output logic [N_EXT-1:0]      ext_done,
  output logic [WORD_W-1:0]     ext_rdata,
  output logic [WORD_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_store,
  output logic [BE_W-1:0]       mem_byte_en,
  output logic                  mem_ren,
  output logic                  mem_wen,
  input  logic                  mem_busy,
  input  logic [WORD_W-1:0]     mem_load,
  output logic                  memory_stall
);

  localparam int IW = idx_w(N_EXT);

  rmgmt_arb_state_t  state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              wen_q, wen_d;
  logic              killed_q, killed_d;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic              in_access;
  logic              done_fire;

  rr_priority_pick #(
    .N  (N_EXT),
    .IW (IW)
  ) u_pick (
    .req   (ext_req),
    .ptr   (rr_ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign in_access = (state_q == ACCESS);
  // A kill arriving in the completing cycle still suppresses the done pulse.
  assign done_fire = in_access && !mem_busy && !killed_q && !kill;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wen_d    = wen_q;
    killed_d = killed_q;
    if (state_q == IDLE) begin
      if (pick_vld && !kill) begin
        state_d = ACCESS;
        idx_d   = pick_idx;
        for (int i = 0; i < N_EXT; i++) begin
          if (pick_idx == IW'(i)) begin
            addr_d  = ext_addr[32*i +: 32];
            wdata_d = ext_wdata[32*i +: 32];
            be_d    = ext_byte_en[4*i +: 4];
            wen_d   = ext_wen[i];
          end
        end
      end
    end else begin
      // Strobes stay up after a kill: a started bus access always runs to completion.
      if (kill) killed_d = 1'b1;
      if (!mem_busy) begin
        state_d  = IDLE;
        killed_d = 1'b0;
        rr_ptr_d = (idx_q == IW'(N_EXT - 1)) ? '0 : idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wen_q    <= 1'b0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wen_q    <= wen_d;
      killed_q <= killed_d;
    end
  end

  always_comb begin
    ext_done = '0;
    for (int i = 0; i < N_EXT; i++) ext_done[i] = done_fire && (idx_q == IW'(i));
  end

  assign ext_rdata    = (done_fire && !wen_q) ? mem_load : '0;
  assign mem_addr     = addr_q;
  assign mem_store    = wdata_q;
  assign mem_byte_en  = be_q;
  assign mem_ren      = in_access && !wen_q;
  assign mem_wen      = in_access && wen_q;
  assign memory_stall = (!in_access && |ext_req) || (in_access && !done_fire);

endmodule
